// File: rtl/ec_fe_addsub_resp.sv
// ---------------------------------------------------------------------------
// ec_fe_addsub_resp
//   Two-stage pipelined modular adder/subtractor over a prime field, with
//   valid/ready handshakes on both sides.
//
//   Stage S1 captures the raw sum (BITS+1 bits) or the difference with its
//   borrow, plus the request tag, mode and operand-range error flag.
//   Stage S2 holds the reduced result. S2 drives the response port directly.
//
// Parameters
//   BITS      field element width
//   P         field modulus (P < 2^BITS); default is the BLS12-381 base prime
//   CTL_BITS  request tag width
//
// Ports
//   i_clk   clock, all logic on the rising edge
//   i_rst   asynchronous reset, active low
//   i_dat   operands: a = i_dat[BITS-1:0], b = i_dat[2*BITS-1:BITS]
//   i_sub   0: a+b mod P, 1: a-b mod P
//   i_ctl   request tag, returned unchanged with the result
//   i_val   request valid
//   o_rdy   request accepted this cycle when i_val is also high
//   o_dat   result
//   o_ctl   tag of the result
//   o_err   an operand of this request was >= P
//   o_val   result valid
//   i_rdy   requester accepts the result
//   o_cnt   number of requests in flight (0..2)
// ---------------------------------------------------------------------------
module ec_fe_addsub_resp #(
  parameter int              BITS     = 381,
  parameter logic [BITS-1:0] P        = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab,
  parameter int              CTL_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [2*BITS-1:0]   i_dat,
  input  logic                i_sub,
  input  logic [CTL_BITS-1:0] i_ctl,
  input  logic                i_val,
  output logic                o_rdy,
  output logic [BITS-1:0]     o_dat,
  output logic [CTL_BITS-1:0] o_ctl,
  output logic                o_err,
  output logic                o_val,
  input  logic                i_rdy,
  output logic [1:0]          o_cnt
);

  // Operand split and raw arithmetic on the request side.
  logic [BITS-1:0] op_a;
  logic [BITS-1:0] op_b;
  logic [BITS:0]   raw_sum;
  logic [BITS:0]   raw_diff;
  logic            in_err;

  assign op_a     = i_dat[BITS-1:0];
  assign op_b     = i_dat[2*BITS-1:BITS];
  assign raw_sum  = {1'b0, op_a} + {1'b0, op_b};
  // Bit BITS of the extended difference is the borrow out of a-b.
  assign raw_diff = {1'b0, op_a} - {1'b0, op_b};
  assign in_err   = (op_a >= P) || (op_b >= P);

  // Stage registers.
  logic                s1_val;
  logic [BITS:0]       s1_r;
  logic [CTL_BITS-1:0] s1_ctl;
  logic                s1_sub;
  logic                s1_err;
  logic                s2_val;

  // Flow control: S2 moves when it is empty or its result is being taken;
  // S1 moves when it is empty or S2 moves. Neither depends on i_val, so
  // o_rdy has no combinational path from the request valid.
  logic s2_adv;
  logic s1_adv;

  assign s2_adv = !s2_val || i_rdy;
  assign s1_adv = !s1_val || s2_adv;
  assign o_rdy  = s1_adv;
  assign o_val  = s2_val;
  assign o_cnt  = {1'b0, s1_val} + {1'b0, s2_val};

  // Reduction of the S1 raw value. Both corrections are done in BITS-bit
  // arithmetic: the add correction never exceeds 2^BITS after subtracting P
  // for in-range operands, and the sub correction wraps mod 2^BITS by design.
  logic [BITS-1:0] add_minus_p;
  logic [BITS-1:0] sub_plus_p;
  logic [BITS-1:0] reduced;

  assign add_minus_p = s1_r[BITS-1:0] - P;
  assign sub_plus_p  = s1_r[BITS-1:0] + P;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    reduced = s1_r[BITS-1:0];
    if (!s1_sub) begin
      if (s1_r >= {1'b0, P}) reduced = add_minus_p;
    end else if (s1_r[BITS]) begin
      reduced = sub_plus_p;
    end
  end

  // S1: captures a request only on an accepted handshake; payload is left
  // untouched otherwise so idle inputs are ignored.
  // NOTE: state registers use non-blocking assignments so every flop in the
  // pipeline samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_val <= 1'b0;
      s1_r   <= '0;
      s1_ctl <= '0;
      s1_sub <= 1'b0;
      s1_err <= 1'b0;
    end else if (s1_adv) begin
      s1_val <= i_val;
      if (i_val) begin
        s1_r   <= i_sub ? raw_diff : raw_sum;
        s1_ctl <= i_ctl;
        s1_sub <= i_sub;
        s1_err <= in_err;
      end
    end
  end

  // S2: holds the reduced result; frozen while a valid result is stalled.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s2_val <= 1'b0;
      o_dat  <= '0;
      o_ctl  <= '0;
      o_err  <= 1'b0;
    end else if (s2_adv) begin
      s2_val <= s1_val;
      if (s1_val) begin
        o_dat <= reduced;
        o_ctl <= s1_ctl;
        o_err <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_ec_fe_addsub_resp.sv
// ---------------------------------------------------------------------------
// tb_ec_fe_addsub_resp
//   Directed and randomised checks of ec_fe_addsub_resp with BITS=4, P=13.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ec_fe_addsub_resp;

  localparam int              BITS     = 4;
  localparam logic [BITS-1:0] P        = 4'd13;
  localparam int              CTL_BITS = 8;

  logic                i_clk;
  logic                i_rst;
  logic [2*BITS-1:0]   i_dat;
  logic                i_sub;
  logic [CTL_BITS-1:0] i_ctl;
  logic                i_val;
  logic                o_rdy;
  logic [BITS-1:0]     o_dat;
  logic [CTL_BITS-1:0] o_ctl;
  logic                o_err;
  logic                o_val;
  logic                i_rdy;
  logic [1:0]          o_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [BITS-1:0]     dat;
    logic [CTL_BITS-1:0] ctl;
    logic                err;
  } exp_t;

  exp_t sb_q[$];

  ec_fe_addsub_resp #(.BITS(BITS), .P(P), .CTL_BITS(CTL_BITS)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_dat (i_dat),
    .i_sub (i_sub),
    .i_ctl (i_ctl),
    .i_val (i_val),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_ctl (o_ctl),
    .o_err (o_err),
    .o_val (o_val),
    .i_rdy (i_rdy),
    .o_cnt (o_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input bit sub, input int ctl);
    i_dat = {b[BITS-1:0], a[BITS-1:0]};
    i_sub = sub;
    i_ctl = ctl[CTL_BITS-1:0];
    i_val = 1'b1;
  endtask

  // Reference reduction written from the field definition of the operation:
  // add subtracts P once when the sum reaches P; sub adds P (mod 2^BITS) on borrow.
  function automatic logic [BITS-1:0] model(input int a, input int b, input bit sub);
    int r;
    if (!sub) begin
      r = a + b;
      if (r >= 13) r = r - 13;
    end else begin
      r = a - b;
      if (r < 0) r = r + 16 + 13;
    end
    return r[BITS-1:0];
  endfunction

  // One isolated request with i_rdy held high: result appears two edges later.
  task automatic req_and_check(input string tag, input int a, input int b, input bit sub,
                               input int ctl, input int exp_dat, input bit exp_err);
    drive(a, b, sub, ctl);
    tick();
    i_val = 1'b0;
    tick();
    check({tag, "_val"}, o_val, 1);
    check({tag, "_dat"}, o_dat, exp_dat);
    check({tag, "_ctl"}, o_ctl, ctl);
    check({tag, "_err"}, o_err, exp_err);
    tick();
  endtask

  initial begin
    i_rst = 1'b1;
    i_dat = '0;
    i_sub = 1'b0;
    i_ctl = '0;
    i_val = 1'b0;
    i_rdy = 1'b0;
    #1 i_rst = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_val", o_val, 0);
    check("rst_dat", o_dat, 0);
    check("rst_ctl", o_ctl, 0);
    check("rst_err", o_err, 0);
    check("rst_cnt", o_cnt, 0);
    check("rst_rdy", o_rdy, 1);

    // Release with a request already presented: taken on the first edge.
    i_rst = 1'b1;
    i_rdy = 1'b1;
    drive(7, 9, 1'b0, 8'h11);
    #1;
    check("first_rdy", o_rdy, 1);
    tick();
    i_val = 1'b0;
    check("first_lat1_val", o_val, 0);
    check("first_lat1_cnt", o_cnt, 1);
    tick();
    check("first_val", o_val, 1);
    check("first_dat", o_dat, 3);
    check("first_ctl", o_ctl, 8'h11);
    check("first_err", o_err, 0);
    tick();
    check("first_drained_val", o_val, 0);
    check("first_drained_cnt", o_cnt, 0);

    // Subtraction wrap, zero result, add reduction at the top of the field.
    req_and_check("sub_3_5", 3, 5, 1'b1, 8'h21, 11, 1'b0);
    req_and_check("sub_5_5", 5, 5, 1'b1, 8'h22, 0, 1'b0);
    req_and_check("add_12_12", 12, 12, 1'b0, 8'h23, 11, 1'b0);

    // Out-of-range operand flags the request; the next clean one does not.
    req_and_check("err_14_1", 14, 1, 1'b0, 8'h31, 2, 1'b1);
    req_and_check("ok_1_1", 1, 1, 1'b0, 8'h32, 2, 1'b0);

    // Back-to-back with the consumer stalled, then drained.
    i_rdy = 1'b0;
    drive(1, 1, 1'b0, 1);
    #1;
    check("bp_rdy1", o_rdy, 1);
    tick();
    drive(2, 1, 1'b0, 2);
    #1;
    check("bp_rdy2", o_rdy, 1);
    tick();
    drive(3, 1, 1'b0, 3);
    #1;
    check("bp_rdy3", o_rdy, 0);
    check("bp_cnt_full", o_cnt, 2);
    check("bp_hold_ctl0", o_ctl, 1);
    tick();
    check("bp_rdy_still0", o_rdy, 0);
    check("bp_cnt_still2", o_cnt, 2);
    check("bp_hold_val", o_val, 1);
    check("bp_hold_ctl", o_ctl, 1);
    check("bp_hold_dat", o_dat, 2);
    i_rdy = 1'b1;
    #1;
    check("bp_rdy_release", o_rdy, 1);
    tick();
    check("bp_out2_ctl", o_ctl, 2);
    check("bp_out2_dat", o_dat, 3);
    drive(4, 1, 1'b0, 4);
    tick();
    i_val = 1'b0;
    check("bp_out3_ctl", o_ctl, 3);
    check("bp_out3_dat", o_dat, 4);
    check("bp_out3_cnt", o_cnt, 2);
    tick();
    check("bp_out4_ctl", o_ctl, 4);
    check("bp_out4_dat", o_dat, 5);
    check("bp_out4_cnt", o_cnt, 1);
    tick();
    check("bp_empty_val", o_val, 0);

    // Asynchronous reset with two requests in flight.
    i_rdy = 1'b0;
    drive(2, 2, 1'b0, 8'h41);
    tick();
    drive(3, 3, 1'b0, 8'h42);
    tick();
    i_val = 1'b0;
    check("ar_cnt_before", o_cnt, 2);
    #2 i_rst = 1'b0;
    #1;
    check("ar_val", o_val, 0);
    check("ar_cnt", o_cnt, 0);
    check("ar_dat", o_dat, 0);
    check("ar_rdy", o_rdy, 1);
    tick();
    i_rst = 1'b1;
    i_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ar_no_stale", o_val, 0);
    end
    req_and_check("ar_fresh", 12, 12, 1'b0, 8'h5A, 11, 1'b0);

    // Random handshakes against the scoreboard.
    begin
      int tag;
      tag = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        int a;
        int b;
        bit sub;
        bit acc;
        bit res;
        exp_t e;
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        sub = 1'($urandom_range(0, 1));
        i_rdy = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) drive(a, b, sub, tag);
        else i_val = 1'b0;
        #1;
        acc = i_val && o_rdy;
        res = o_val && i_rdy;
        if (res) begin
          if (sb_q.size() == 0) begin
            check("rnd_unexpected_result", o_val, 0);
          end else begin
            e = sb_q.pop_front();
            check("rnd_result", {o_dat, o_ctl, o_err}, e);
          end
        end
        if (acc) begin
          e.dat = model(a, b, sub);
          e.ctl = tag[CTL_BITS-1:0];
          e.err = (a >= 13) || (b >= 13);
          sb_q.push_back(e);
          tag++;
        end
        tick();
      end
      i_val = 1'b0;
      i_rdy = 1'b1;
      for (int k = 0; k < 8 && sb_q.size() != 0; k++) begin
        exp_t e;
        #1;
        if (o_val) begin
          e = sb_q.pop_front();
          check("rnd_drain", {o_dat, o_ctl, o_err}, e);
        end
        tick();
      end
      check("rnd_all_returned", sb_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ec_fe_addsub_resp.md
EC_FE_ADDSUB_RESP -- requirements
Module: ec_fe_addsub_resp

Interface
REQ-001 SHALL have parameter BITS, default 381, meaning field element width.
REQ-002 SHALL have parameter P, default BLS12-381 base-field prime, meaning modulus (BITS wide, P < 2^BITS).
REQ-003 SHALL have parameter CTL_BITS, default 8, meaning request tag width.
REQ-004 SHALL have port i_clk  in  1  meaning single clock, all logic rising-edge.
REQ-005 SHALL have port i_rst  in  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port i_dat  in  2*BITS  meaning operands; a = [BITS-1:0], b = [2*BITS-1:BITS].
REQ-007 SHALL have port i_sub  in  1  meaning 0 = a+b mod P, 1 = a-b mod P; sampled with i_val.
REQ-008 SHALL have port i_ctl  in  CTL_BITS  meaning request tag, returned unchanged.
REQ-009 SHALL have port i_val  in  1  meaning request valid.
REQ-010 SHALL have port o_rdy  out  1  meaning responder accepts request this cycle.
REQ-011 SHALL have port o_dat  out  BITS  meaning result.
REQ-012 SHALL have port o_ctl  out  CTL_BITS  meaning tag of the result.
REQ-013 SHALL have port o_err  out  1  meaning an operand of this request was >= P.
REQ-014 SHALL have port o_val  out  1  meaning result valid.
REQ-015 SHALL have port i_rdy  in  1  meaning requester accepts result.
REQ-016 SHALL have port o_cnt  out  2  meaning number of requests in flight (0..2).

Function
REQ-017 SHALL transfer a request on a rising edge where i_val && o_rdy, and a result where o_val && i_rdy.
REQ-018 SHALL use two register stages: S1 holds raw r = a+b (BITS+1 bits) or a-b with borrow, plus tag, mode, err; S2 holds the reduced result = o_dat/o_ctl/o_err, with o_val = S2 valid.
REQ-019 SHALL reduce in S1->S2: add: r >= P ? r-P : r; sub: borrow ? r+P (mod 2^BITS) : r.
REQ-020 SHALL have latency exactly 2 cycles from request acceptance to o_val with i_rdy held 1.
REQ-021 SHALL sustain one request per cycle with i_rdy held 1.
REQ-022 SHALL advance S2 when !o_val || i_rdy; S1 advances when S1 empty or S2 advances; o_rdy = !S1valid || S2 advances (combinational, no path from i_val).
REQ-023 SHALL hold o_dat, o_ctl, o_err, o_val stable while o_val && !i_rdy.
REQ-024 SHALL on simultaneous result-out and request-in keep both stages full with no bubble and no loss.
REQ-025 SHALL set err = (a >= P) || (b >= P) at acceptance, still compute per REQ-019, and never drop or reorder the request.
REQ-026 SHALL return results in acceptance order with the tag of the originating request.
REQ-027 SHALL keep o_cnt = S1valid + S2valid, updated same edge as the stage valids.
REQ-028 SHALL ignore i_dat, i_sub, i_ctl when i_val is 0 or o_rdy is 0.

Reset
REQ-029 SHALL while i_rst is 0 force o_val=0, o_dat=0, o_ctl=0, o_err=0, o_cnt=0, S1valid=0, with o_rdy=1.
REQ-030 SHALL on reset assertion mid-operation discard all in-flight requests immediately; no result is produced for them after release.
REQ-031 SHALL accept a request on the first rising edge after i_rst deasserts.

Verification (BITS=4, P=13)
REQ-032 SHALL check: add a=7,b=9,ctl=0x11 -> two cycles later o_val=1, o_dat=3, o_ctl=0x11, o_err=0.
REQ-033 SHALL check: sub a=3,b=5 -> o_dat=11; sub a=5,b=5 -> 0; add a=12,b=12 -> 11.
REQ-034 SHALL check: four back-to-back requests (tags 1..4), i_rdy=0 throughout -> o_rdy falls after 2 accepted, o_cnt=2, o_dat/o_ctl stable; raising i_rdy drains tags 1,2,3,4 in order, one per cycle once 3 and 4 are accepted.
REQ-035 SHALL check: add a=14,b=1 -> o_err=1, o_dat=2; next request a=1,b=1 -> o_err=0, o_dat=2.
REQ-036 SHALL check: reset asserted with o_cnt=2 -> o_val=0, o_cnt=0 asynchronously; no stale result after release; fresh request returns correct value in 2 cycles.
REQ-037 SHALL check: random stimulus with random i_val/i_rdy against a reference model -> every result matches (a±b) mod P and tags arrive in order.
